// File: rtl/softmax_io_pkg.sv
// Shared widths, state encoding and job-size helper for the softmax host stream port.
package softmax_io_pkg;

    localparam int ADDR_W        = 5;
    localparam int BEAT_W        = 32;
    localparam int DATA_W        = 1024;
    localparam int MODE_W        = 4;
    localparam int ROW_W         = DATA_W + MODE_W;
    localparam int BEATS_PER_ROW = DATA_W / BEAT_W;
    localparam int BEAT_CNT_W    = $clog2(BEATS_PER_ROW);
    localparam int MAX_ROWS      = 1 << ADDR_W;
    localparam int TIMEOUT_CYC   = 16;
    localparam int TIMER_W       = $clog2(TIMEOUT_CYC);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        KICK,
        WAIT_HI,
        WAIT_LO,
        RD,
        RD_WAIT,
        DRAIN,
        DONE
    } state_t;

    // Index of the final row of a job: 0 behaves as one row, anything above MAX_ROWS saturates.
    function automatic logic [ADDR_W-1:0] last_row_idx(input logic [ADDR_W:0] num_rows);
        logic [ADDR_W:0] n;
        if (num_rows == '0)
            n = (ADDR_W+1)'(1);
        else if (num_rows > (ADDR_W+1)'(MAX_ROWS))
            n = (ADDR_W+1)'(MAX_ROWS);
        else
            n = num_rows;
        n = n - (ADDR_W+1)'(1);
        return n[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/softmax_host_port_beat_shreg.sv
// Row-wide shift register: parallel load, or shift right one beat with a new beat entering at the top.
// Packing shifts input beats in; unpacking shifts zeros in while beats leave from the bottom.
module beat_shreg #(
    parameter int WIDTH = 1024,
    parameter int BEAT  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic [BEAT-1:0]  i_beat,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_q <= '0;
        else if (i_en) begin
            if (i_load)
                o_q <= i_load_data;
            else if (i_shift)
                o_q <= {i_beat, o_q[WIDTH-1:BEAT]};
        end
    end

endmodule

// File: rtl/softmax_host_port.sv
// Host stream endpoint: packs beats into BRAM rows, kicks bram_fsm, then streams result rows back out.
//
// state   | meaning
// IDLE    | waiting for i_go
// LOAD    | packing input beats; one write cycle after each full row
// KICK    | start pulse to bram_fsm, BRAM handed over
// WAIT_HI | waiting for busy to rise (16-cycle timeout)
// WAIT_LO | waiting for busy to fall
// RD      | port B read of the current row
// RD_WAIT | capture read data into the shift register
// DRAIN   | emitting 32 beats of the current row
// DONE    | one-cycle done pulse
module softmax_host_port
    import softmax_io_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_go,
    input  logic [ADDR_W:0]   i_num_rows,
    input  logic [MODE_W-1:0] i_mode,
    input  logic              s_valid,
    input  logic [BEAT_W-1:0] s_data,
    output logic              s_ready,
    output logic              o_start,
    input  logic              i_busy,
    output logic              o_host_sel,
    output logic              o_cena,
    output logic              o_wea,
    output logic [ADDR_W-1:0] o_addra,
    output logic [ROW_W-1:0]  o_dina,
    output logic              o_cenb,
    output logic [ADDR_W-1:0] o_addrb,
    input  logic [ROW_W-1:0]  i_doutb,
    output logic              m_valid,
    output logic [BEAT_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic              o_done
);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       row_q, last_row_q;
    logic [BEAT_CNT_W-1:0]   beat_q;
    logic [MODE_W-1:0]       mode_q;
    logic [TIMER_W-1:0]      timer_q;
    logic                    wr_pend_q;
    logic [DATA_W-1:0]       shreg_q;
    logic                    shreg_load, shreg_shift;
    logic [BEAT_W-1:0]       shreg_beat;
    logic                    last_beat, last_row;
    logic                    unused_doutb_mode;

    assign last_beat = (beat_q == BEAT_CNT_W'(BEATS_PER_ROW - 1));
    assign last_row  = (row_q == last_row_q);
    assign unused_doutb_mode = ^i_doutb[ROW_W-1:DATA_W];

    beat_shreg #(.WIDTH(DATA_W), .BEAT(BEAT_W)) u_shreg (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_load      (shreg_load),
        .i_shift     (shreg_shift),
        .i_load_data (i_doutb[DATA_W-1:0]),
        .i_beat      (shreg_beat),
        .o_q         (shreg_q)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= IDLE;
        else if (i_en)
            state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        s_ready     = 1'b0;
        o_start     = 1'b0;
        o_host_sel  = 1'b1;
        o_cena      = 1'b0;
        o_wea       = 1'b0;
        o_cenb      = 1'b0;
        m_valid     = 1'b0;
        m_last      = 1'b0;
        o_done      = 1'b0;
        shreg_load  = 1'b0;
        shreg_shift = 1'b0;
        shreg_beat  = '0;
        case (state_q)
            IDLE: if (i_go) state_d = LOAD;
            LOAD: begin
                if (wr_pend_q) begin
                    o_cena = 1'b1;
                    o_wea  = 1'b1;
                    if (last_row) state_d = KICK;
                end else begin
                    s_ready = i_en;
                    if (s_valid) begin
                        shreg_shift = 1'b1;
                        shreg_beat  = s_data;
                    end
                end
            end
            KICK: begin
                o_host_sel = 1'b0;
                o_start    = 1'b1;
                state_d    = WAIT_HI;
            end
            WAIT_HI: begin
                o_host_sel = 1'b0;
                if (i_busy || timer_q == '0) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                o_host_sel = 1'b0;
                if (!i_busy) state_d = RD;
            end
            RD: begin
                o_cenb  = 1'b1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                shreg_load = 1'b1;
                state_d    = DRAIN;
            end
            DRAIN: begin
                m_valid = i_en;
                m_last  = i_en && last_beat && last_row;
                if (m_ready) begin
                    shreg_shift = 1'b1;
                    if (last_beat) state_d = last_row ? DONE : RD;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters advance only on the cycles the state machine consumes or produces a beat/row.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_q      <= '0;
            last_row_q <= '0;
            beat_q     <= '0;
            mode_q     <= '0;
            timer_q    <= '0;
            wr_pend_q  <= 1'b0;
        end else if (i_en) begin
            case (state_q)
                IDLE: if (i_go) begin
                    last_row_q <= last_row_idx(i_num_rows);
                    mode_q     <= i_mode;
                    row_q      <= '0;
                    beat_q     <= '0;
                    wr_pend_q  <= 1'b0;
                end
                LOAD: begin
                    if (wr_pend_q) begin
                        wr_pend_q <= 1'b0;
                        row_q     <= last_row ? '0 : row_q + ADDR_W'(1);
                    end else if (s_valid) begin
                        beat_q <= beat_q + BEAT_CNT_W'(1);
                        if (last_beat) wr_pend_q <= 1'b1;
                    end
                end
                KICK:    timer_q <= TIMER_W'(TIMEOUT_CYC - 1);
                WAIT_HI: if (timer_q != '0) timer_q <= timer_q - TIMER_W'(1);
                RD_WAIT: beat_q <= '0;
                DRAIN: if (m_ready) begin
                    beat_q <= beat_q + BEAT_CNT_W'(1);
                    if (last_beat && !last_row) row_q <= row_q + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_addra = o_cena ? row_q : '0;
    assign o_dina  = o_cena ? {mode_q, shreg_q} : '0;
    assign o_addrb = o_cenb ? row_q : '0;
    assign m_data  = m_valid ? shreg_q[BEAT_W-1:0] : '0;

endmodule

// File: tb/tb_softmax_host_port.sv
// Randomized bench for softmax_host_port with a BRAM model, a stand-in bram_fsm and a stream scoreboard.
module tb_softmax_host_port;
    import softmax_io_pkg::*;

    logic              i_clk = 1'b0;
    logic              i_rst, i_en, i_go;
    logic [ADDR_W:0]   i_num_rows;
    logic [MODE_W-1:0] i_mode;
    logic              s_valid;
    logic [BEAT_W-1:0] s_data;
    logic              s_ready, o_start, i_busy, o_host_sel, o_cena, o_wea, o_cenb;
    logic [ADDR_W-1:0] o_addra, o_addrb;
    logic [ROW_W-1:0]  o_dina, i_doutb;
    logic              m_valid, m_last, m_ready, o_done;
    logic [BEAT_W-1:0] m_data;

    softmax_host_port dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_go(i_go),
        .i_num_rows(i_num_rows), .i_mode(i_mode),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .o_start(o_start), .i_busy(i_busy), .o_host_sel(o_host_sel),
        .o_cena(o_cena), .o_wea(o_wea), .o_addra(o_addra), .o_dina(o_dina),
        .o_cenb(o_cenb), .o_addrb(o_addrb), .i_doutb(i_doutb),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [BEAT_W-1:0] beats[$];
    logic [BEAT_W-1:0] exp_q[$];
    logic [ROW_W-1:0]  mem[MAX_ROWS];
    int   in_idx, wr_row, n_eff, start_cnt, done_cnt, fsm_left, cyc, start_cyc, cenb_cyc;
    int   gap_pct, stall_pct;
    bit   job_active, busy_en, expect_done, job_fin, prev_stall, go_req, drain_go, drain_go_sent;
    logic [MODE_W-1:0] job_mode;
    logic [BEAT_W-1:0] prev_data;

    // The stand-in bram_fsm rewrites each row's data by XOR with a row key when it runs.
    function automatic logic [BEAT_W-1:0] key(input int r);
        return 32'hA5C3_0000 | 32'(r);
    endfunction

    task automatic step();
        logic [BEAT_W-1:0] e;
        @(negedge i_clk);
        cyc++;
        if (expect_done) begin
            chk("done_pulse", o_done, 1);
            expect_done = 0;
            job_fin = 1;
        end
        if (o_done) done_cnt++;

        i_go = go_req;
        go_req = 0;
        if (drain_go && !drain_go_sent && m_valid) begin
            i_go = 1;
            i_num_rows = 5;
            drain_go_sent = 1;
        end

        if (job_active && in_idx < beats.size()) begin
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = beats[in_idx];
        end else begin
            s_valid = 0;
            s_data  = $urandom;
        end
        if (s_valid && s_ready) in_idx++;

        m_ready = ($urandom_range(99) >= stall_pct);
        if (m_valid) begin
            if (prev_stall) chk("m_hold", m_data, prev_data);
            if (m_ready) begin
                if (exp_q.size() == 0) chk("m_extra", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("m_data", m_data, e);
                    chk("m_last", m_last, exp_q.size() == 0);
                    if (exp_q.size() == 0) expect_done = 1;
                end
            end
            prev_stall = !m_ready;
            prev_data  = m_data;
        end else
            prev_stall = 0;

        if (o_cena && o_wea) begin
            chk("wr_addr", o_addra, wr_row);
            chk("wr_mode", o_dina[ROW_W-1:DATA_W], job_mode);
            if (wr_row < n_eff)
                for (int k = 0; k < BEATS_PER_ROW; k++)
                    chk("wr_beat", o_dina[k*BEAT_W +: BEAT_W], beats[wr_row*BEATS_PER_ROW + k]);
            mem[o_addra] = o_dina;
            wr_row++;
        end
        if (o_cenb) begin
            chk("rd_owner", o_host_sel, 1);
            if (cenb_cyc < 0) cenb_cyc = cyc;
            i_doutb = mem[o_addrb];
        end
        if (!o_host_sel) chk("own_en", {o_cena, o_cenb}, 2'b00);

        if (o_start) begin
            start_cnt++;
            start_cyc = cyc;
            if (busy_en) fsm_left = 6;
        end
        if (fsm_left > 0) begin
            fsm_left--;
            i_busy = (fsm_left != 0);
            if (fsm_left == 0)
                for (int r = 0; r < n_eff; r++)
                    for (int k = 0; k < BEATS_PER_ROW; k++)
                        mem[r][k*BEAT_W +: BEAT_W] = mem[r][k*BEAT_W +: BEAT_W] ^ key(r);
        end
    endtask

    task automatic run_job(input int n_req, input logic [MODE_W-1:0] mode, input int gap,
                           input int stall, input bit b_en, input bit fixed, input bit d_go,
                           input int abort_at);
        n_eff = (n_req == 0) ? 1 : ((n_req > MAX_ROWS) ? MAX_ROWS : n_req);
        beats.delete();
        exp_q.delete();
        for (int i = 0; i < n_eff*BEATS_PER_ROW; i++)
            beats.push_back(fixed ? 32'h100 + 32'(i) : 32'($urandom));
        for (int r = 0; r < n_eff; r++)
            for (int k = 0; k < BEATS_PER_ROW; k++)
                exp_q.push_back(beats[r*BEATS_PER_ROW + k] ^ (b_en ? key(r) : 32'h0));
        in_idx = 0; wr_row = 0; start_cnt = 0; done_cnt = 0; fsm_left = 0;
        cenb_cyc = -1; start_cyc = -1; i_busy = 0;
        expect_done = 0; job_fin = 0; prev_stall = 0;
        drain_go = d_go; drain_go_sent = 0; busy_en = b_en; job_mode = mode;
        gap_pct = gap; stall_pct = stall; job_active = 1;
        i_num_rows = (ADDR_W+1)'(n_req);
        i_mode = mode;
        go_req = 1;

        for (int c = 0; c < n_eff*250 + 300; c++) begin
            step();
            if (abort_at >= 0 && in_idx > abort_at) begin
                @(posedge i_clk);
                #2 i_rst = 1;
                #1;
                chk("abort_sready", s_ready, 0);
                chk("abort_host_sel", o_host_sel, 1);
                chk("abort_cena", o_cena, 0);
                chk("abort_mvalid", m_valid, 0);
                chk("abort_rows_written", wr_row, abort_at / BEATS_PER_ROW);
                job_active = 0;
                repeat (3) step();
                i_rst = 0;
                repeat (3) step();
                chk("abort_no_more_wr", wr_row, abort_at / BEATS_PER_ROW);
                chk("abort_no_start", start_cnt, 0);
                chk("abort_idle", s_ready, 0);
                return;
            end
            if (job_fin) break;
        end
        job_active = 0;
        chk("job_finished", job_fin, 1);
        chk("start_cnt", start_cnt, 1);
        chk("rows_written", wr_row, n_eff);
        chk("beats_in", in_idx, n_eff*BEATS_PER_ROW);
        if (!b_en) chk("timeout_latency", cenb_cyc - start_cyc, 18);
        repeat (5) step();
        chk("done_once", done_cnt, 1);
        chk("back_idle", s_ready, 0);
        chk("host_sel_idle", o_host_sel, 1);
    endtask

    initial begin
        i_rst = 1; i_en = 1; i_go = 0; i_num_rows = '0; i_mode = '0;
        s_valid = 0; s_data = '0; i_busy = 0; m_ready = 0; i_doutb = '0;
        go_req = 0; job_active = 0; expect_done = 0; fsm_left = 0; cyc = 0;
        prev_stall = 0; drain_go = 0; drain_go_sent = 0; n_eff = 1;
        for (int r = 0; r < MAX_ROWS; r++) mem[r] = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_sready", s_ready, 0);
        chk("rst_host_sel", o_host_sel, 1);
        chk("rst_start", o_start, 0);
        chk("rst_cena", {o_cena, o_wea}, 0);
        chk("rst_cenb", o_cenb, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_done", o_done, 0);
        i_rst = 0;
        repeat (2) step();

        run_job(1,  4'h3, 0,  0,  1, 1, 0, -1);   // fixed 0x100+k pattern, single row
        run_job(32, 4'hA, 30, 0,  1, 0, 0, -1);   // full BRAM with input gaps
        run_job(3,  4'h5, 10, 50, 1, 0, 0, -1);   // output back-pressure
        run_job(2,  4'h1, 0,  20, 0, 0, 0, -1);   // busy never rises
        run_job(4,  4'h7, 0,  0,  1, 0, 0, 2*BEATS_PER_ROW + 17);
        run_job(1,  4'h2, 0,  0,  1, 0, 0, -1);   // clean job after reset
        run_job(2,  4'h9, 0,  30, 1, 0, 1, -1);   // i_go during DRAIN
        run_job(0,  4'h4, 20, 20, 1, 0, 0, -1);   // zero rows acts as one
        run_job(63, 4'hF, 0,  0,  1, 0, 0, -1);   // saturates at 32 rows

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/softmax_host_port.md
Name: softmax_host_port

Overview:
- Host-side stream endpoint for the softmax BRAM subsystem; it is the opposite end of the BRAM that bram_fsm consumes.
- Accepts a 32-bit beat stream, packs 32 beats per 1028-bit row ({mode[3:0], x[1023:0]}) and writes the rows into BRAM port A.
- Pulses the start of bram_fsm and waits for its busy to fall.
- Reads the result rows back on port B and serialises them as a 32-bit output stream.
- Owns the BRAM ports only while o_host_sel=1; the top level muxes BRAM ports between this block and bram_fsm.

Parameters:
- ADDR_W, 5, BRAM address width (32 rows).
- BEAT_W, 32, stream beat width.
- DATA_W, 1024, feature bits per row.
- MODE_W, 4, length-mode bits per row (row width = DATA_W+MODE_W = 1028).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_en  in  1  global enable; when low, all state and outputs hold
- i_go  in  1  single-cycle pulse; begins a job when in IDLE, ignored otherwise
- i_num_rows  in  ADDR_W+1  rows in the job, 1..32; sampled on i_go
- i_mode  in  MODE_W  length mode written into every row; sampled on i_go
- s_valid  in  1  input beat valid
- s_data  in  BEAT_W  input beat
- s_ready  out  1  input beat accepted when s_valid&s_ready
- o_start  out  1  start pulse to bram_fsm
- i_busy  in  1  busy from bram_fsm
- o_host_sel  out  1  1 = this block owns the BRAM ports
- o_cena  out  1  port A chip enable
- o_wea  out  1  port A write enable
- o_addra  out  ADDR_W  port A address
- o_dina  out  DATA_W+MODE_W  port A write data
- o_cenb  out  1  port B chip enable
- o_addrb  out  ADDR_W  port B address
- i_doutb  in  DATA_W+MODE_W  port B read data, valid one cycle after o_cenb
- m_valid  out  1  output beat valid
- m_data  out  BEAT_W  output beat
- m_last  out  1  marks the final beat of the job
- m_ready  in  1  downstream accepts the beat
- o_done  out  1  one-cycle pulse when the last beat is accepted

Behaviour:
- Reset values: all outputs 0 except o_host_sel=1; state IDLE; counters 0.
- IDLE: on i_go, latch i_num_rows (0 is treated as 1; values above 32 saturate to 32) and i_mode, clear row and beat counters, go to LOAD.
- LOAD:
  - s_ready=1 except in the cycle the row write is issued.
  - Beat k of a row fills bits [32k+31:32k]; beat 0 is the LSBs.
  - On beat 31 accept: next cycle assert o_cena=o_wea=1, o_addra=row, o_dina={mode, packed} for exactly one cycle, with s_ready=0 in that cycle.
  - After the final row's write, go to KICK.
- Back-pressure: s_valid low stalls the packer with no data loss.
- KICK: o_host_sel=0 and o_start=1 for one cycle, then go to WAIT_HI.
- WAIT_HI: wait for i_busy=1, then go to WAIT_LO. A 16-cycle timeout with busy never seen also advances to WAIT_LO.
- WAIT_LO: on i_busy=0, set o_host_sel=1 and go to RD.
- RD: o_cenb=1 and o_addrb=row for one cycle, then go to RD_WAIT.
- RD_WAIT: capture i_doutb[DATA_W-1:0] into the shift register, then go to DRAIN.
- DRAIN:
  - m_valid=1 and m_data=shreg[31:0]; shift right 32 on each m_valid&m_ready.
  - m_data must hold stable while m_valid&!m_ready.
  - After beat 31: if more rows remain, increment row and go to RD; otherwise go to DONE.
  - m_last=1 only on beat 31 of the last row.
- DONE: o_done=1 for one cycle, then go to IDLE.
- Ownership: o_host_sel=0 exactly from KICK through WAIT_LO. All BRAM enables from this block are 0 during that window.
- Asynchronous reset mid-job: immediately return to IDLE. A partial row is discarded; BRAM contents are not touched.
- i_go outside IDLE: ignored.
- Latency: from the first accepted input beat to the first output beat = 33·N load cycles (minimum) + fsm time + 2.

Decomposition:
- Package softmax_io_pkg holds ADDR_W, BEAT_W, DATA_W, MODE_W, ROW_W, BEATS_PER_ROW=DATA_W/BEAT_W, and the state enum (IDLE, LOAD, KICK, WAIT_HI, WAIT_LO, RD, RD_WAIT, DRAIN, DONE).
- One sub-module, beat_shreg: a parametric 1024-bit register with load-parallel, shift-in-beat and shift-out-beat modes, shared by the pack and unpack paths.

Test Plan:
- Single row, mode=4'h3, beats 0..31 with values 32'h100+k, s_valid held high:
  - Expect one write at addr 0 with dina[1027:1024]=3 and dina[31:0]=32'h100, dina[1023:992]=32'h11F.
  - Expect one o_start pulse, then 32 output beats in order with m_last on the 32nd, and o_done one cycle after it.
- i_num_rows=32 with random s_valid gaps: expect writes to addrs 0..31 in order and no dropped beats; the output stream equals the model of the softmax applied to each row.
- m_ready toggling 1/0 during DRAIN: m_data must stay stable while stalled, with no duplicated or missing beats.
- bram_fsm never asserts busy: expect a 16-cycle timeout, then the readback proceeds and o_host_sel returns to 1.
- Asynchronous reset asserted at beat 17 of row 2: expect an immediate return to IDLE with s_ready=0, o_host_sel=1 and no further writes; a following job with i_num_rows=1 completes normally.
- i_go pulsed during DRAIN: expect it to be ignored, with the current job ending with exactly one o_done.
